// File: rtl/uart_tx_if.sv
// UART transmitter control interface: payload request in, output-mux control and status out.
// The FSM connects through the slave modport; the driver of payload and frame options uses master.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            MUX_SEL;
  logic                  SER_DATA;
  logic                  PAR_BIT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  MUX_SEL, SER_DATA, PAR_BIT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output MUX_SEL, SER_DATA, PAR_BIT, BUSY
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: start, LSB-first data, optional parity, stop; one bit per CLK.
// All outputs are registered from the next-state values, so they line up with the state register.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [DATA_WIDTH-1:0] data_r, data_nxt_s;
  logic                  par_en_r, par_en_nxt_s;
  logic                  par_typ_r, par_typ_nxt_s;
  logic [1:0]            mux_r, mux_nxt_s;
  logic                  ser_r, ser_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  par_r, par_nxt_s;

  // Even parity is the XOR of the payload; odd parity inverts it.
  function automatic logic parity_calc(input logic [DATA_WIDTH-1:0] d, input logic odd);
    parity_calc = (^d) ^ odd;
  endfunction

  // Next-state, counter and payload-latch logic.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    data_nxt_s    = data_r;
    par_en_nxt_s  = par_en_r;
    par_typ_nxt_s = par_typ_r;
    case (state_r)
      IDLE, STOP: begin
        if (bus.DATA_VALID) begin
          state_nxt_s   = START;
          data_nxt_s    = bus.P_DATA;
          par_en_nxt_s  = bus.PAR_EN;
          par_typ_nxt_s = bus.PAR_TYP;
        end else begin
          state_nxt_s = IDLE;
        end
        cnt_nxt_s = {CNT_W{1'b0}};
      end
      START: begin
        state_nxt_s = DATA;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      DATA: begin
        if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
          state_nxt_s = par_en_r ? PARITY : STOP;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = DATA;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      PARITY: begin
        state_nxt_s = STOP;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values for the state being entered; anything outside START..PARITY idles high.
  always_comb begin
    mux_nxt_s  = 2'b01;
    ser_nxt_s  = 1'b0;
    busy_nxt_s = (state_nxt_s != IDLE);
    par_nxt_s  = parity_calc(data_nxt_s, par_typ_nxt_s);
    case (state_nxt_s)
      START:   mux_nxt_s = 2'b00;
      DATA: begin
        mux_nxt_s = 2'b10;
        ser_nxt_s = data_nxt_s[cnt_nxt_s];
      end
      PARITY:  mux_nxt_s = 2'b11;
      default: mux_nxt_s = 2'b01;
    endcase
  end

  // State, latches and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      mux_r     <= 2'b01;
      ser_r     <= 1'b0;
      busy_r    <= 1'b0;
      par_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      data_r    <= data_nxt_s;
      par_en_r  <= par_en_nxt_s;
      par_typ_r <= par_typ_nxt_s;
      mux_r     <= mux_nxt_s;
      ser_r     <= ser_nxt_s;
      busy_r    <= busy_nxt_s;
      par_r     <= par_nxt_s;
    end
  end

  assign bus.MUX_SEL  = mux_r;
  assign bus.SER_DATA = ser_r;
  assign bus.BUSY     = busy_r;
  assign bus.PAR_BIT  = par_r;
endmodule
